// File: rtl/hv_bundler.sv
// hv_bundler: binds and bundles N_FEAT level hypervectors into one sample HV.
//
// A sample of N_FEAT feature HVs is captured on the input handshake. One
// feature per cycle is (optionally) rotated left by its feature index and
// added into per-bit saturating counters. The counters are then compared
// against the captured threshold to form out_hv. out_hv is presented with a
// valid/ready handshake.
//
// Optional build macro: HV_PERMUTE_BIND_EN
//   defined   : feature k is rotated left by k before bundling (positional bind)
//   undefined : features are bundled unrotated (plain bundling)
//
// Ports:
//   clk        clock
//   nrst       synchronous active-low reset
//   in_valid   sample present on in_hv / threshold
//   in_ready   block can accept a sample (IDLE only)
//   in_hv      N_FEAT*D feature HVs, feature k at [k*D +: D]
//   threshold  bundling threshold, sampled at accept
//   out_valid  out_hv holds a completed sample HV
//   out_ready  downstream accepts out_hv (ignored outside OUT)
//   out_hv     bundled, thresholded sample HV
//   busy       high in any state other than IDLE
module hv_bundler #(
  parameter int unsigned D      = 5000,
  parameter int unsigned N_FEAT = 10,
  parameter int unsigned CNT_W  = 4
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [N_FEAT*D-1:0]   in_hv,
  input  logic [CNT_W-1:0]      threshold,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [D-1:0]          out_hv,
  output logic                  busy
);

  localparam int unsigned KW = (N_FEAT > 1) ? $clog2(N_FEAT) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(N_FEAT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    THRESH,
    OUT
  } state_t;

  state_t                  state;
  logic [KW-1:0]           k;
  logic [N_FEAT*D-1:0]     feat_reg;
  logic [CNT_W-1:0]        thr_reg;
  logic [D-1:0][CNT_W-1:0] cnt;
  logic [D-1:0]            feat_cur;
  logic [D-1:0]            rot;

  // The captured sample is shifted down by D every ACCUM cycle, so the
  // current feature is always the low slice; this avoids an N_FEAT-way
  // wide mux indexed by k.
  assign feat_cur = feat_reg[D-1:0];

  always_comb begin
    rot = feat_cur;
`ifdef HV_PERMUTE_BIND_EN
    // Left rotate by k: rot[b] = feat[(b-k) mod D]. For k=0 the right
    // shift is by the full width and contributes nothing.
    rot = (feat_cur << k) | (feat_cur >> (D - int'(k)));
`else
    rot = feat_cur;
`endif
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state     <= IDLE;
      k         <= '0;
      feat_reg  <= '0;
      thr_reg   <= '0;
      cnt       <= '0;
      out_hv    <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            feat_reg <= in_hv;
            thr_reg  <= threshold;
            cnt      <= '0;
            k        <= '0;
            state    <= ACCUM;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end

        ACCUM: begin
          for (int unsigned b = 0; b < D; b++) begin
            if (rot[b] && (cnt[b] != CNT_MAX)) begin
              cnt[b] <= cnt[b] + 1'b1;
            end
          end
          feat_reg <= feat_reg >> D;
          if (k == K_LAST) begin
            state <= THRESH;
          end else begin
            k <= k + 1'b1;
          end
        end

        THRESH: begin
          for (int unsigned b = 0; b < D; b++) begin
            out_hv[b] <= (cnt[b] >= thr_reg);
          end
          state     <= OUT;
          out_valid <= 1'b1;
        end

        OUT: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
          end
        end

        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hv_bundler.sv
// tb_hv_bundler: self-checking bench for hv_bundler.
// Directed cases for reset, binding, thresholds, wrap-around, backpressure
// and mid-operation reset, followed by randomized samples checked against a
// per-bit counting model. Expectations follow HV_PERMUTE_BIND_EN the same way
// the design build does.
module tb_hv_bundler;

  localparam int unsigned D      = 5000;
  localparam int unsigned N_FEAT = 10;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned NW     = N_FEAT * D;
  localparam int          MAXC   = (1 << CNT_W) - 1;

  logic              clk;
  logic              nrst;
  logic              in_valid;
  logic              in_ready;
  logic [NW-1:0]     in_hv;
  logic [CNT_W-1:0]  threshold;
  logic              out_valid;
  logic              out_ready;
  logic [D-1:0]      out_hv;
  logic              busy;

  int n_checks;
  int n_fail;

  hv_bundler #(
    .D(D),
    .N_FEAT(N_FEAT),
    .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .nrst(nrst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_hv(in_hv),
    .threshold(threshold),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_hv(out_hv),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Count, for each output bit, how many features land a 1 on it after
  // binding, clamp at the counter ceiling and compare with the threshold.
  function automatic logic [D-1:0] model(input logic [NW-1:0] hv, input int thr);
    logic [D-1:0] r;
    r = '0;
    for (int b = 0; b < D; b++) begin
      int c;
      c = 0;
      for (int f = 0; f < N_FEAT; f++) begin
        int src;
`ifdef HV_PERMUTE_BIND_EN
        src = ((b - f) % D + D) % D;
`else
        src = b;
`endif
        if (hv[f*D + src]) c++;
      end
      if (c > MAXC) c = MAXC;
      r[b] = (c >= thr);
    end
    return r;
  endfunction

  function automatic logic [NW-1:0] rand_hv(input int pct);
    logic [NW-1:0] v;
    for (int i = 0; i < NW; i++) v[i] = ($urandom_range(0, 99) < pct);
    return v;
  endfunction

  task automatic run_sample(input string tag, input logic [NW-1:0] hv,
                            input logic [CNT_W-1:0] thr, input int stall);
    int cyc;
    int changes;
    int ready_hi;
    logic [D-1:0] exp;
    logic [D-1:0] held;
    cyc = 0;
    while (!in_ready && cyc < 50) begin
      tick();
      cyc++;
    end
    check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    in_hv     = hv;
    threshold = thr;
    in_valid  = 1'b1;
    tick();
    // Scramble inputs after the accept edge: only the accept edge matters.
    in_valid  = 1'b0;
    in_hv     = rand_hv(50);
    threshold = CNT_W'($urandom);
    check({tag, "_busy"}, 64'(busy), 64'd1);
    check({tag, "_in_ready_low"}, 64'(in_ready), 64'd0);
    cyc = 1;
    while (!out_valid && cyc < 40) begin
      tick();
      cyc++;
    end
    check({tag, "_latency"}, 64'(cyc), 64'(N_FEAT + 2));
    exp = model(hv, int'(thr));
    check({tag, "_ones"}, 64'($countones(out_hv)), 64'($countones(exp)));
    check({tag, "_diff_bits"}, 64'($countones(out_hv ^ exp)), 64'd0);
    held     = out_hv;
    changes  = 0;
    ready_hi = 0;
    for (int i = 0; i < stall; i++) begin
      in_valid = 1'b1;
      in_hv    = rand_hv(50);
      threshold = CNT_W'($urandom);
      tick();
      if (out_hv !== held || !out_valid) changes++;
      if (in_ready) ready_hi++;
    end
    if (stall > 0) begin
      check({tag, "_stall_stable"}, 64'(changes), 64'd0);
      check({tag, "_stall_in_ready"}, 64'(ready_hi), 64'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, "_post_valid"}, 64'(out_valid), 64'd0);
    check({tag, "_post_ready"}, 64'(in_ready), 64'd1);
    check({tag, "_post_busy"}, 64'(busy), 64'd0);
    check({tag, "_post_hold"}, 64'($countones(out_hv ^ held)), 64'd0);
  endtask

  initial begin
    logic [NW-1:0] hv;
    logic [NW-1:0] hv2;
    int vhi;
    n_checks  = 0;
    n_fail    = 0;
    nrst      = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_hv     = '0;
    threshold = '0;

    // Reset state
    tick();
    tick();
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_out_hv", 64'($countones(out_hv)), 64'd0);
    nrst = 1'b1;
    tick();

    // Every feature one-hot at bit 0
    hv = '0;
    for (int f = 0; f < N_FEAT; f++) hv[f*D] = 1'b1;
    run_sample("onehot_t1", hv, 4'd1, 0);
    run_sample("onehot_t2", hv, 4'd2, 0);
    run_sample("onehot_t10", hv, 4'd10, 0);
    run_sample("onehot_t11", hv, 4'd11, 0);
    run_sample("onehot_t0", hv, 4'd0, 0);

    // Wrap-around: feature 3 has only bit D-1 set
    hv = '0;
    hv[3*D + D - 1] = 1'b1;
    run_sample("wrap", hv, 4'd1, 0);

    // Backpressure, then the second sample is taken afterwards
    hv  = rand_hv(40);
    hv2 = rand_hv(60);
    run_sample("bp_first", hv, 4'd4, 20);
    run_sample("bp_second", hv2, 4'd6, 0);

    // Reset during ACCUM at k=5
    in_hv    = rand_hv(50);
    threshold = 4'd1;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    nrst = 1'b0;
    tick();
    nrst = 1'b1;
    vhi = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (out_valid) vhi++;
    end
    check("midrst_no_valid", 64'(vhi), 64'd0);
    check("midrst_in_ready", 64'(in_ready), 64'd1);
    check("midrst_out_hv", 64'($countones(out_hv)), 64'd0);
    hv = '1;
    run_sample("midrst_all_ones", hv, 4'd10, 0);
    check("midrst_all_ones_cnt", 64'($countones(out_hv)), 64'(D));

    // Randomized samples
    for (int n = 0; n < 20; n++) begin
      hv = rand_hv($urandom_range(5, 95));
      run_sample("rand", hv, CNT_W'($urandom_range(0, MAXC)), int'($urandom_range(0, 3)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
